// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int DATA_W     = 16;
  localparam int WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // A byte address is rejected when it is not word aligned or its word index
  // lies beyond the array; upper address bits are range-checked, never wrapped.
  function automatic logic addr_bad(input logic [DATA_W-1:0] addr, input int depth);
    logic [DATA_W-1:0] word;
    word = addr >> WORD_SHIFT;
    return (addr[WORD_SHIFT-1:0] != '0) ||
           (int'({{(32-DATA_W){1'b0}}, word}) >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store handshake between the CPU data path (master) and the memory (slave).
interface dmem_responder_if
  import dmem_responder_pkg::*;
();

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err, busy
  );

endinterface

// File: rtl/dmem_responder_array.sv
// DEPTH x 16 storage: synchronous write, combinational read, no reset so
// contents survive a controller reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Commit a store word on the clock edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, then pulses ready with read data or an error flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  dmem_responder_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              busy_q;

  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic              sel_bad;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] resp_rdata;
  logic              arr_we;

  // The response is registered on the edge entering RESP. With zero wait
  // states that edge is also the accepting edge, so the live bus fields are
  // used in IDLE and the latched copies everywhere else.
  always_comb begin
    sel_addr = addr_q;
    sel_we   = we_q;
    if (state_q == IDLE) begin
      sel_addr = bus.addr;
      sel_we   = bus.we;
    end
    sel_bad    = addr_bad(sel_addr, DEPTH);
    sel_idx    = sel_addr[WORD_SHIFT +: IDX_W];
    resp_rdata = (sel_bad || sel_we) ? '0 : arr_rdata;
  end

  // Stores commit as RESP ends; a reset during RESP therefore drops the write.
  assign wr_idx = addr_q[WORD_SHIFT +: IDX_W];
  assign arr_we = (state_q == RESP) && we_q && !err_q;

  // Request sequencing, wait-state countdown and registered response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= sel_bad;
              rdata_q <= resp_rdata;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            err_q   <= sel_bad;
            rdata_q <= resp_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clock),
    .we_i    (arr_we),
    .waddr_i (wr_idx),
    .wdata_i (wdata_q),
    .raddr_i (sel_idx),
    .rdata_o (arr_rdata)
  );

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with WAIT_STATES = 0..3 (index k
// has k wait states), checked against a word-array model of the memory.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst_n_v;
  logic [3:0]       req_v;
  logic [3:0]       we_v;
  logic [3:0][15:0] addr_v;
  logic [3:0][15:0] wdata_v;
  logic [3:0]       ready_v;
  logic [3:0]       err_v;
  logic [3:0]       busy_v;
  logic [3:0][15:0] rdata_v;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mem_m [4][256];
  bit          vld_m [4][256];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder_if u_if ();
    assign u_if.req   = req_v[g];
    assign u_if.we    = we_v[g];
    assign u_if.addr  = addr_v[g];
    assign u_if.wdata = wdata_v[g];
    assign ready_v[g] = u_if.ready;
    assign err_v[g]   = u_if.err;
    assign busy_v[g]  = u_if.busy;
    assign rdata_v[g] = u_if.rdata;

    dmem_responder #(
      .DEPTH       (256),
      .WAIT_STATES (g)
    ) u_dut (
      .clock   (clk),
      .reset_n (rst_n_v[g]),
      .bus     (u_if.slave)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_bad(input logic [15:0] a);
    return (a[1:0] != 2'b00) || (int'(a >> 2) >= 256);
  endfunction

  // One complete request on instance k, checked against the model.
  task automatic run_txn(input int k, input bit w, input logic [15:0] a,
                         input logic [15:0] d, input string tag);
    bit          bad;
    bit          rd_known;
    logic [15:0] exp_rd;
    int          n;
    int          idx;
    bad      = exp_bad(a);
    idx      = int'(a >> 2);
    rd_known = 1'b1;
    exp_rd   = 16'h0000;
    if (!bad && !w) begin
      rd_known = vld_m[k][idx];
      exp_rd   = mem_m[k][idx];
    end
    req_v[k]   = 1'b1;
    we_v[k]    = w;
    addr_v[k]  = a;
    wdata_v[k] = d;
    tick();
    req_v[k]   = 1'b0;
    we_v[k]    = 1'($urandom);
    addr_v[k]  = 16'($urandom);
    wdata_v[k] = 16'($urandom);
    n = 1;
    vectors++;
    if (busy_v[k] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_accept: got %b expected 1", tag, busy_v[k]);
    end
    while (ready_v[k] !== 1'b1 && n < 24) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== k + 1) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", tag, n, k + 1);
    end
    vectors++;
    if (err_v[k] !== bad) begin
      miscompares++;
      $display("FAIL %s err: got %b expected %b", tag, err_v[k], bad);
    end
    if (rd_known) begin
      vectors++;
      if (rdata_v[k] !== exp_rd) begin
        miscompares++;
        $display("FAIL %s rdata: got %h expected %h", tag, rdata_v[k], exp_rd);
      end
    end
    vectors++;
    if (busy_v[k] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_at_ready: got %b expected 1", tag, busy_v[k]);
    end
    tick();
    vectors++;
    if ({ready_v[k], busy_v[k], err_v[k]} !== 3'b000 || rdata_v[k] !== 16'h0000) begin
      miscompares++;
      $display("FAIL %s after_resp: got ready=%b busy=%b err=%b rdata=%h expected all 0",
               tag, ready_v[k], busy_v[k], err_v[k], rdata_v[k]);
    end
    if (!bad && w) begin
      mem_m[k][idx] = d;
      vld_m[k][idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n_v = '0;
    req_v   = '0;
    we_v    = '0;
    addr_v  = '0;
    wdata_v = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ready_v[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ready[%0d]: got %b expected 0", k, ready_v[k]);
      end
      vectors++;
      if (err_v[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_err[%0d]: got %b expected 0", k, err_v[k]);
      end
      vectors++;
      if (busy_v[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_v[k]);
      end
      vectors++;
      if (rdata_v[k] !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_rdata[%0d]: got %h expected 0000", k, rdata_v[k]);
      end
    end
    tick();
    tick();
    rst_n_v = '1;
    tick();
  endtask

  task automatic test_store_load();
    run_txn(2, 1'b1, 16'd0, 16'h0005, "sl_store0");
    run_txn(2, 1'b1, 16'd4, 16'h0007, "sl_store4");
    run_txn(2, 1'b0, 16'd0, 16'h0000, "sl_load0");
    run_txn(2, 1'b0, 16'd4, 16'h0000, "sl_load4");
  endtask

  task automatic test_zero_wait();
    run_txn(0, 1'b1, 16'd12, 16'hFFFE, "zw_store");
    run_txn(0, 1'b0, 16'd12, 16'h0000, "zw_load");
  endtask

  task automatic test_errors();
    run_txn(2, 1'b0, 16'h0006, 16'h0000, "err_misaligned");
    run_txn(2, 1'b1, 16'h0400, 16'hBEEF, "err_range");
    run_txn(2, 1'b1, 16'h0003, 16'hDEAD, "err_misaligned_st");
    run_txn(2, 1'b0, 16'h0000, 16'h0000, "err_word0");
  endtask

  task automatic test_reset_mid();
    run_txn(3, 1'b1, 16'd8, 16'h1234, "rm_prime");
    req_v[3]   = 1'b1;
    we_v[3]    = 1'b1;
    addr_v[3]  = 16'd8;
    wdata_v[3] = 16'h00AA;
    tick();
    req_v[3] = 1'b0;
    tick();
    #2;
    rst_n_v[3] = 1'b0;
    #1;
    vectors++;
    if ({ready_v[3], err_v[3], busy_v[3]} !== 3'b000 || rdata_v[3] !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got ready=%b err=%b busy=%b rdata=%h expected all 0",
               ready_v[3], err_v[3], busy_v[3], rdata_v[3]);
    end
    tick();
    rst_n_v[3] = 1'b1;
    tick();
    vectors++;
    if (busy_v[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle_busy: got %b expected 0", busy_v[3]);
    end
    run_txn(3, 1'b0, 16'd8, 16'h0000, "rm_load");
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last;
    pulses = 0;
    last   = 0;
    req_v[1]   = 1'b1;
    we_v[1]    = 1'b1;
    addr_v[1]  = 16'd16;
    wdata_v[1] = 16'h0123;
    for (int n = 1; n <= 9; n++) begin
      tick();
      vectors++;
      if (ready_v[1] !== ((n % 3) == 2)) begin
        miscompares++;
        $display("FAIL b2b_ready cycle %0d: got %b expected %b", n, ready_v[1], (n % 3) == 2);
      end
      vectors++;
      if (busy_v[1] !== ((n % 3) != 0)) begin
        miscompares++;
        $display("FAIL b2b_busy cycle %0d: got %b expected %b", n, busy_v[1], (n % 3) != 0);
      end
      if (ready_v[1] === 1'b1) begin
        if (pulses > 0) begin
          vectors++;
          if (n - last !== 3) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d expected 3", n - last);
          end
        end
        pulses++;
        last = n;
      end
    end
    req_v[1] = 1'b0;
    vectors++;
    if (pulses !== 3) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d expected 3", pulses);
    end
    tick();
    vectors++;
    if (busy_v[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_released_busy: got %b expected 0", busy_v[1]);
    end
    mem_m[1][4] = 16'h0123;
    vld_m[1][4] = 1'b1;
    run_txn(1, 1'b0, 16'd16, 16'h0000, "b2b_load");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 15; t++) begin
        int          sel;
        logic [15:0] a;
        sel = int'($urandom_range(0, 9));
        if (sel < 7)       a = 16'($urandom_range(0, 31)) << 2;
        else if (sel == 7) a = (16'($urandom_range(0, 31)) << 2) | 16'($urandom_range(1, 3));
        else if (sel == 8) a = 16'h0400 | (16'($urandom_range(0, 255)) << 2);
        else               a = 16'($urandom);
        run_txn(k, 1'($urandom), a, 16'($urandom), "random");
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        vld_m[k][i] = 1'b0;
        mem_m[k][i] = 16'h0000;
      end
    end
    test_reset();
    test_store_load();
    test_zero_wait();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
